// File: rtl/serial_add_controller.sv
// Serial add/subtract controller: pushes a W-bit operation through a single
// 4-bit carry-lookahead slice, one nibble per cycle, LSB nibble first.

module lookahead_adder_4bits (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] g, p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Carries computed in parallel from generate/propagate terms
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ c[3:0];
    assign cout = c[4];
endmodule

module serial_add_controller #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf,
    output logic                 busy
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q;
    logic [W-1:0]  a_q, b_q, sum_q;
    logic          sub_q, carry_q, cout_q, ovf_q;
    logic [IW-1:0] idx_q;

    logic [3:0]    nib_a, nib_b, add_s;
    logic          add_co;

    assign nib_a = a_q[{idx_q, 2'b00} +: 4];
    assign nib_b = b_q[{idx_q, 2'b00} +: 4] ^ {4{sub_q}};

    lookahead_adder_4bits u_add (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q     <= a;
                    b_q     <= b;
                    sub_q   <= sub;
                    idx_q   <= '0;
                    carry_q <= sub;   // +1 completes the two's-complement negate
                    state_q <= RUN;
                end
                RUN: begin
                    sum_q[{idx_q, 2'b00} +: 4] <= add_s;
                    carry_q <= add_co;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        cout_q  <= add_co;
                        ovf_q   <= (a_q[W-1] == (b_q[W-1] ^ sub_q)) && (add_s[3] != a_q[W-1]);
                        state_q <= DONE;
                    end
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_serial_add_controller.sv
// Bench for serial_add_controller: directed corner cases plus random
// operations compared against an integer-arithmetic reference model.

module tb_serial_add_controller;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst, in_valid, sub, out_ready;
    logic [W-1:0] a, b;
    logic         in_ready, out_valid, cout, ovf, busy;
    logic [W-1:0] sum;

    int errs   = 0;
    int checks = 0;

    serial_add_controller #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns {ovf, cout, sum} from plain integer arithmetic
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic s);
        int sx, sy, r, ux, uy;
        logic [15:0] res;
        logic co, ov;
        sx = int'($signed(x));
        sy = int'($signed(y));
        ux = int'(x);
        uy = int'(y);
        r  = s ? sx - sy : sx + sy;
        ov = (r > 32767) || (r < -32768);
        co = s ? (ux >= uy) : (ux + uy > 65535);
        res = s ? x - y : x + y;
        return {ov, co, res};
    endfunction

    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic s,
                          input int hold, input bit scramble, output logic [17:0] got);
        logic [17:0] snap;
        a = x; b = y; sub = s; in_valid = 1'b1;
        chk("ready_before_accept", in_ready, 1);
        tick();
        chk("busy_after_accept", busy, 1);
        chk("ready_in_run", in_ready, 0);
        for (int k = 1; k <= N; k++) begin
            if (scramble) begin
                a = W'($urandom); b = W'($urandom); sub = 1'($urandom); in_valid = 1'($urandom);
            end
            if (k == N) in_valid = 1'b1;   // a request waiting while DONE
            tick();
            if (k < N) chk("valid_early", out_valid, 0);
            else       chk("valid_at_latency", out_valid, 1);
        end
        snap = {ovf, cout, sum};
        for (int h = 0; h < hold; h++) begin
            a = W'($urandom); in_valid = 1'b1;
            tick();
            chk("hold_result", {ovf, cout, sum}, snap);
            chk("hold_valid", out_valid, 1);
            chk("hold_ready_low", in_ready, 0);
        end
        got = {ovf, cout, sum};
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("idle_after_consume", in_ready, 1);
        chk("valid_cleared", out_valid, 0);
        chk("not_busy_idle", busy, 0);
    endtask

    typedef struct {
        logic [15:0] x, y;
        logic        s;
        logic [15:0] es;
        logic        ec, eo;
    } vec_t;

    vec_t        dir[5];
    logic [17:0] got;
    logic [15:0] rx, ry;
    logic        rs;

    initial begin
        dir[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
        dir[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        dir[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        dir[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        dir[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; sub = 1'b0;
        a = 16'hAAAA; b = 16'h5555;
        tick(); tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", {ovf, cout, sum}, 0);

        foreach (dir[i]) begin
            run_op(dir[i].x, dir[i].y, dir[i].s, (i == 0) ? 3 : i % 3, i[0], got);
            chk("dir_sum", got[15:0], dir[i].es);
            chk("dir_cout", got[16], dir[i].ec);
            chk("dir_ovf", got[17], dir[i].eo);
        end

        // Abort an operation partway through with reset
        a = 16'h1111; b = 16'h2222; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_ready", in_ready, 1);
        chk("midrst_sum", sum, 0);
        chk("midrst_busy", busy, 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("midrst_no_valid", out_valid, 0);
        end
        run_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0, got);
        chk("post_rst_op", got, {1'b0, 1'b0, 16'h0002});

        for (int t = 0; t < 40; t++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            rs = 1'($urandom);
            if (t % 8 == 0) ry = rx;                    // equal operands: zero / borrow edge
            if (t % 8 == 1) begin rx = 16'h8000; ry = 16'($urandom_range(0, 3)); end
            run_op(rx, ry, rs, int'($urandom_range(0, 3)), 1'b1, got);
            chk("rand_result", got, model(rx, ry, rs));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
